// File: rtl/image_ram_pkg.sv
// image_ram_pkg: shared defaults and encodings for the image RAM write path.
//   IMG_W_DEF / IMG_H_DEF : default image geometry (row stride / row count)
//   ADDR_W_DEF / DATA_W_DEF : default RAM address and pixel widths (RGB332)
//   CMD_W                 : width of the rectangle fields on the command port
//   mode_e                : command mode (solid fill or pixel stream)
//   state_e               : writer FSM states
package image_ram_pkg;

    localparam int IMG_W_DEF  = 320;
    localparam int IMG_H_DEF  = 140;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int CMD_W      = 10;

    typedef enum logic {
        MODE_FILL   = 1'b0,
        MODE_STREAM = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/rect_addr_gen.sv
// rect_addr_gen: walks a rectangle in raster order inside an image of stride IMG_W.
//   clk, rst   : clock, synchronous active-low reset
//   load_i     : start a new rectangle (base_i = y*IMG_W+x, w_i, h_i latched)
//   advance_i  : consume the current address and step to the next pixel
//   addr_o     : current RAM address (row_base + col)
//   last_o     : current address is the bottom-right pixel of the rectangle
module rect_addr_gen
    import image_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IMG_W  = IMG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [CMD_W-1:0]  w_i,
    input  logic [CMD_W-1:0]  h_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [CMD_W-1:0]  col_q, row_q, w_q, h_q;
    logic [ADDR_W-1:0] row_base_q;
    logic              col_end, row_end;

    assign col_end = (col_q == w_q - CMD_W'(1));
    assign row_end = (row_q == h_q - CMD_W'(1));
    assign last_o  = col_end && row_end;
    assign addr_o  = row_base_q + ADDR_W'(col_q);

    // The row start advances by the stride at each row wrap, so the loop
    // never needs a multiplier.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
            row_base_q <= '0;
        end else if (load_i) begin
            col_q      <= '0;
            row_q      <= '0;
            w_q        <= w_i;
            h_q        <= h_i;
            row_base_q <= base_i;
        end else if (advance_i) begin
            if (col_end) begin
                col_q      <= '0;
                row_q      <= row_q + CMD_W'(1);
                row_base_q <= row_base_q + ADDR_W'(IMG_W);
            end else begin
                col_q <= col_q + CMD_W'(1);
            end
        end
    end

endmodule

// File: rtl/image_ram_writer.sv
// image_ram_writer: fills a rectangle of the image RAM write port, either with a
// solid colour or with a raster-order pixel stream.
//   cmd_*     : command handshake and rectangle/mode/colour (accepted only in IDLE)
//   px_*      : stream pixels, valid/ready handshake, consumed only while writing
//   vblank    : display blanking; gates the first write when SYNC_VBLANK=1
//   wren, wraddress, data : registered RAM write port
//   busy      : command in progress; done: one-cycle completion pulse
//   err       : one-cycle pulse for a rejected (empty or out-of-image) command
module image_ram_writer
    import image_ram_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter bit SYNC_VBLANK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [CMD_W-1:0]  cmd_x,
    input  logic [CMD_W-1:0]  cmd_y,
    input  logic [CMD_W-1:0]  cmd_w,
    input  logic [CMD_W-1:0]  cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    input  logic              px_valid,
    input  logic [DATA_W-1:0] px_data,
    output logic              px_ready,
    input  logic              vblank,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    mode_e             mode_q;
    logic [DATA_W-1:0] color_q;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddress_q, wraddress_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              accept, cmd_ok, load, beat, last;
    logic [ADDR_W-1:0] base, addr;

    // One extra bit on the sums so x+w and y+h cannot wrap past the image edge.
    assign cmd_ok = (cmd_w != '0) && (cmd_h != '0)
                 && (({1'b0, cmd_x} + {1'b0, cmd_w}) <= (CMD_W+1)'(IMG_W))
                 && (({1'b0, cmd_y} + {1'b0, cmd_h}) <= (CMD_W+1)'(IMG_H));
    assign accept = cmd_valid && cmd_ready;
    assign load   = accept && cmd_ok;
    // The only multiply in the design; it runs once per command.
    assign base   = ADDR_W'(32'(cmd_y) * 32'(IMG_W) + 32'(cmd_x));

    rect_addr_gen #(
        .ADDR_W (ADDR_W),
        .IMG_W  (IMG_W)
    ) u_addr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .base_i    (base),
        .w_i       (cmd_w),
        .h_i       (cmd_h),
        .advance_i (beat),
        .addr_o    (addr),
        .last_o    (last)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready   = (state_q == IDLE);
        px_ready    = (state_q == WRITE) && (mode_q == MODE_STREAM);
        beat        = (state_q == WRITE) && ((mode_q == MODE_FILL) || px_valid);
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        err_d       = accept && !cmd_ok;
        wren_d      = beat;
        wraddress_d = wraddress_q;
        data_d      = data_q;
        if (beat) begin
            wraddress_d = addr;
            data_d      = (mode_q == MODE_FILL) ? color_q : px_data;
        end
        case (state_q)
            IDLE:    if (load) state_d = SYNC_VBLANK ? WAIT_VB : WRITE;
            WAIT_VB: if (vblank) state_d = WRITE;
            WRITE:   if (beat && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_FILL;
            color_q     <= '0;
            wren_q      <= 1'b0;
            wraddress_q <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wren_q      <= wren_d;
            wraddress_q <= wraddress_d;
            data_q      <= data_d;
            err_q       <= err_d;
            if (load) begin
                mode_q  <= mode_e'(cmd_mode);
                color_q <= cmd_color;
            end
        end
    end

    assign wren      = wren_q;
    assign wraddress = wraddress_q;
    assign data      = data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_image_ram_writer.sv
module tb_image_ram_writer;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_valid_v, cmd_mode;
    logic [9:0] cmd_x, cmd_y, cmd_w, cmd_h;
    logic [7:0] cmd_color, px_data;
    logic       px_valid, vblank;

    logic        cmd_ready0, px_ready0, wren0, busy0, done0, err0;
    logic [15:0] wraddress0;
    logic [7:0]  data0;
    logic        cmd_ready1, px_ready1, wren1, busy1, done1, err1;
    logic [15:0] wraddress1;
    logic [7:0]  data1;

    int  total_checks  = 0;
    int  passed_checks = 0;
    int  wr_cnt        = 0;
    int  done_cnt      = 0;
    int  last_addr     = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    image_ram_writer #(.SYNC_VBLANK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_mode(cmd_mode), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready0),
        .vblank(vblank), .wren(wren0), .wraddress(wraddress0), .data(data0),
        .busy(busy0), .done(done0), .err(err0)
    );

    image_ram_writer #(.SYNC_VBLANK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_v), .cmd_ready(cmd_ready1),
        .cmd_mode(cmd_mode), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .px_valid(1'b0), .px_data(px_data), .px_ready(px_ready1),
        .vblank(vblank), .wren(wren1), .wraddress(wraddress1), .data(data1),
        .busy(busy1), .done(done1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) begin
            passed_checks++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.addr = 16'(a);
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic set_cmd(input logic m, input int x, input int y, input int w, input int h,
                           input logic [7:0] c);
        cmd_mode  = m;
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = c;
    endtask

    task automatic wait_done0(input int max_cycles, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done0) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic clip_case(input int x, input int y, input int w, input int h, input string tag);
        set_cmd(1'b0, x, y, w, h, 8'hFF);
        cmd_valid = 1'b1;
        @(negedge clk);
        check({tag, "_ready_before"}, 32'(cmd_ready0), 32'd1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check({tag, "_err"}, 32'(err0), 32'd1);
        check({tag, "_ready"}, 32'(cmd_ready0), 32'd1);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
        check({tag, "_wren"}, 32'(wren0), 32'd0);
        step();
        @(negedge clk);
        check({tag, "_err_one_cycle"}, 32'(err0), 32'd0);
        check({tag, "_wren_after"}, 32'(wren0), 32'd0);
    endtask

    // Scoreboard: every write on dut0 must match the next queued expectation.
    always @(negedge clk) begin
        if (done0) done_cnt++;
        if (wren0) begin
            wr_t e;
            wr_cnt++;
            last_addr = int'(wraddress0);
            if (exp_q.size() == 0) begin
                check("unexpected_wr_addr", 32'(wraddress0), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wraddress0), 32'(e.addr));
                check("wr_data", 32'(data0), 32'(e.d));
                $display("write addr=%0d data=%02h", wraddress0, data0);
            end
        end
    end

    initial begin
        int wr_start, done_start;
        rst = 1'b0; cmd_valid = 1'b0; cmd_valid_v = 1'b0; px_valid = 1'b0;
        px_data = 8'h00; vblank = 1'b0;
        set_cmd(1'b0, 0, 0, 0, 0, 8'h00);

        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_wren", 32'(wren0), 32'd0);
        check("rst_addr", 32'(wraddress0), 32'd0);
        check("rst_data", 32'(data0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_px_ready", 32'(px_ready0), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready0), 32'd1);
        step();
        rst = 1'b1;

        // Fill 2x2 at (3,1)
        set_cmd(1'b0, 3, 1, 2, 2, 8'hE0);
        push_wr(323, 8'hE0); push_wr(324, 8'hE0); push_wr(643, 8'hE0); push_wr(644, 8'hE0);
        cmd_valid = 1'b1;
        @(negedge clk);
        check("fill_cmd_ready", 32'(cmd_ready0), 32'd1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("fill_first_cycle_wren", 32'(wren0), 32'd0);
        check("fill_busy", 32'(busy0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("fill_wren", 32'(wren0), 32'd1);
            check("fill_done", 32'(done0), 32'(i == 3));
            check("fill_busy_run", 32'(busy0), 32'd1);
        end
        step();
        @(negedge clk);
        check("fill_end_wren", 32'(wren0), 32'd0);
        check("fill_end_ready", 32'(cmd_ready0), 32'd1);
        check("fill_end_busy", 32'(busy0), 32'd0);

        // Stream 3x1 at (0,0) with a one-cycle stall
        step();
        set_cmd(1'b1, 0, 0, 3, 1, 8'h00);
        push_wr(0, 8'h11); push_wr(1, 8'h22); push_wr(2, 8'h33);
        cmd_valid = 1'b1; px_valid = 1'b1; px_data = 8'h11;
        @(negedge clk);
        check("stream_idle_px_ready", 32'(px_ready0), 32'd0);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("stream_px_ready", 32'(px_ready0), 32'd1);
        step();
        px_valid = 1'b0;
        @(negedge clk);
        check("stream_wren_b1", 32'(wren0), 32'd1);
        step();
        px_valid = 1'b1; px_data = 8'h22;
        @(negedge clk);
        check("stream_stall_gap", 32'(wren0), 32'd0);
        step();
        px_data = 8'h33;
        @(negedge clk);
        check("stream_wren_b2", 32'(wren0), 32'd1);
        step();
        px_valid = 1'b0;
        @(negedge clk);
        check("stream_px_ready_drop", 32'(px_ready0), 32'd0);
        check("stream_wren_b3", 32'(wren0), 32'd1);
        check("stream_done", 32'(done0), 32'd1);
        step();
        @(negedge clk);
        check("stream_end_ready", 32'(cmd_ready0), 32'd1);
        check("stream_end_wren", 32'(wren0), 32'd0);

        // Rejected commands
        step();
        clip_case(319, 0, 2, 1, "clip_x");
        step();
        clip_case(0, 0, 1, 0, "clip_h0");
        step();
        clip_case(0, 139, 1, 2, "clip_y");

        // Vblank gating on the synced instance
        step();
        set_cmd(1'b0, 0, 0, 1, 1, 8'h5A);
        cmd_valid_v = 1'b1;
        step();
        cmd_valid_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("vb_hold_wren", 32'(wren1), 32'd0);
            check("vb_hold_busy", 32'(busy1), 32'd1);
            step();
        end
        vblank = 1'b1;
        @(negedge clk);
        check("vb_rise_wren", 32'(wren1), 32'd0);
        step();
        @(negedge clk);
        check("vb_rise1_wren", 32'(wren1), 32'd0);
        step();
        @(negedge clk);
        check("vb_wren", 32'(wren1), 32'd1);
        check("vb_addr", 32'(wraddress1), 32'd0);
        check("vb_data", 32'(data1), 32'h5A);
        check("vb_done", 32'(done1), 32'd1);
        $display("vblank write addr=%0d data=%02h", wraddress1, data1);
        step();
        vblank = 1'b0;
        @(negedge clk);
        check("vb_end_busy", 32'(busy1), 32'd0);

        // Reset in the middle of a 6-pixel stream
        step();
        set_cmd(1'b1, 0, 0, 6, 1, 8'h00);
        push_wr(0, 8'hA0); push_wr(1, 8'hA1);
        cmd_valid = 1'b1; px_valid = 1'b1; px_data = 8'hA0;
        step();
        cmd_valid = 1'b0;
        step();
        px_data = 8'hA1;
        step();
        px_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("mid_busy_before_rst", 32'(busy0), 32'd1);
        step();
        @(negedge clk);
        check("mid_rst_wren", 32'(wren0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_px_ready", 32'(px_ready0), 32'd0);
        step();
        rst = 1'b1;
        set_cmd(1'b0, 10, 2, 2, 1, 8'h3C);
        push_wr(650, 8'h3C); push_wr(651, 8'h3C);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        wait_done0(20, "after_rst_done");
        step();
        @(negedge clk);
        check("after_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Full-frame fill
        step();
        wr_start   = wr_cnt;
        done_start = done_cnt;
        for (int i = 0; i < 44800; i++) push_wr(i, 8'h1C);
        set_cmd(1'b0, 0, 0, 320, 140, 8'h1C);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        wait_done0(50000, "frame_done");
        step();
        @(negedge clk);
        check("frame_write_count", 32'(wr_cnt - wr_start), 32'd44800);
        check("frame_last_addr", 32'(last_addr), 32'd44799);
        check("frame_done_count", 32'(done_cnt - done_start), 32'd1);
        check("frame_queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame_cmd_ready", 32'(cmd_ready0), 32'd1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/image_ram_writer.md
Name: image_ram_writer

Overview:
- Write-side counterpart to the VGA image display path: fills rectangular regions of an image RAM through its write port (wraddress/data/wren).
- Two command modes: solid-colour fill, or a pixel stream accepted over a valid/ready handshake.
- Sits between game/menu control logic and the dual-port image RAM. The VGA display reads the same RAM on its read port.
- Optional vblank gating keeps on-screen updates from tearing.

Parameters:
- IMG_W, 320, image width in pixels (row stride of the RAM)
- IMG_H, 140, image height in rows
- ADDR_W, 16, RAM address width
- DATA_W, 8, pixel width (RGB332)
- SYNC_VBLANK, 1, when 1 the first write of each command waits for vblank=1

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous reset, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  1  0 = fill with cmd_color, 1 = stream from px_*
- cmd_x  in  10  rectangle left column
- cmd_y  in  10  rectangle top row
- cmd_w  in  10  rectangle width
- cmd_h  in  10  rectangle height
- cmd_color  in  DATA_W  fill colour
- px_valid  in  1  stream pixel valid
- px_data  in  DATA_W  stream pixel, raster order
- px_ready  out  1  stream pixel accept
- vblank  in  1  display vertical blanking indicator
- wren  out  1  RAM write enable
- wraddress  out  ADDR_W  RAM write address
- data  out  DATA_W  RAM write data
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejected-command pulse

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; wren=0, wraddress=0, data=0, busy=0, done=0, err=0, px_ready=0, cmd_ready=1 from the next cycle. Reset mid-command abandons the command; no further writes.
- States: IDLE, WAIT_VB, WRITE, DONE.
- IDLE, handshake: cmd_ready=1; accept on cmd_valid&cmd_ready.
- IDLE, validation: reject if w==0, h==0, x+w>IMG_W or y+h>IMG_H, using 11-bit sums with no wrap.
  - On reject: err=1 for the next cycle only, stay IDLE, no writes.
- IDLE, on accept: latch x, w, h, mode and colour; row_base=y*IMG_W+x (registered); col=0, row=0.
  - Next state is WAIT_VB if SYNC_VBLANK=1, else WRITE.
- WAIT_VB: busy=1; move to WRITE on the first cycle vblank=1. Writes do not pause if vblank later deasserts.
- WRITE, beat definition:
  - fill mode: a beat every cycle.
  - stream mode: px_ready=1 throughout WRITE; a beat is px_valid&px_ready.
- Write timing: a beat accepted in cycle N gives wren=1 in cycle N+1, with wraddress=row_base+col and data = colour (fill) or px_data (stream). wren=0 in any cycle without a beat.
- Address increment: col+1; at col==w-1, col=0, row+1 and row_base+=IMG_W. No multiplier inside the loop.
- Last beat (col==w-1, row==h-1) goes to DONE. px_ready drops in the cycle after the last beat.
- DONE: lasts one cycle, coincident with the final wren; done=1, busy=1. Then IDLE, with cmd_ready=1 the following cycle.
- busy=1 in WAIT_VB, WRITE and DONE.
- Max address: (IMG_H-1)*IMG_W+IMG_W-1 = 44799 < 2^16.
- cmd_* is ignored while busy. px_valid outside WRITE/stream is ignored and never consumed.

Decomposition:
- Package image_ram_pkg:
  - IMG_W/IMG_H defaults
  - mode encoding (MODE_FILL=0, MODE_STREAM=1)
  - state encoding (IDLE=0, WAIT_VB=1, WRITE=2, DONE=3)
  - DATA_W/ADDR_W
- Sub-module rect_addr_gen: col/row counters, row_base accumulator, advance input, last output. Top level keeps the FSM, the handshakes and the output registers.

Test Plan:
- Fill, SYNC_VBLANK=0: x=3, y=1, w=2, h=2, colour 0xE0 → wren on 4 consecutive cycles, addresses 323, 324, 643, 644, data 0xE0; done coincides with the 4th wren; cmd_ready high 2 cycles after.
- Stream with stalls: x=0, y=0, w=3, h=1, px_valid pattern 1,0,1,1 with data 0x11, –, 0x22, 0x33 → writes 0:0x11, 1:0x22, 2:0x33; the wren gap matches the stall; px_ready low after the 3rd beat.
- Clip error: x=319, w=2 (and separately h=0) → err=1 for exactly 1 cycle, no wren, cmd_ready stays 1.
- Vblank gating, SYNC_VBLANK=1: fill accepted with vblank=0 for 10 cycles → no wren and busy=1; first wren 2 cycles after vblank rises.
- Reset mid-stream: rst=0 after 2 of 6 beats → wren=0, busy=0, px_ready=0 the next cycle; a new fill command executes normally.
- Full-frame fill: x=0, y=0, w=320, h=140 → 44800 writes, last address 44799, exactly one done pulse.
